// File: rtl/cpu_pkg.sv
// Shared widths and constants for the single-cycle CPU datapath blocks.
package cpu_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_select.sv
// Write-back steering: picks the destination register and the data written to it.
module wb_select
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DATA_W,
  parameter int AW = cpu_pkg::ADDR_W
) (
  input  logic          RegDst,
  input  logic          MemtoReg,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic [DW-1:0] ALUData,
  input  logic [DW-1:0] DMData,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata
);

  // RegDst=1 for R-type (rd), 0 for loads/immediates (rt).
  assign waddr = RegDst ? rd : rt;
  assign wdata = MemtoReg ? DMData : ALUData;

endmodule

// File: rtl/reg_file.sv
// 32 x 32-bit register file: two combinational read ports, one clocked write port
// with built-in write-back select. Register 0 reads as zero and ignores writes.
module reg_file
  import cpu_pkg::*;
#(
  parameter int DW    = cpu_pkg::DATA_W,
  parameter int AW    = cpu_pkg::ADDR_W,
  parameter int NREGS = cpu_pkg::NUM_REGS
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  input  logic [AW-1:0] rd,
  input  logic          RegWrite,
  input  logic          RegDst,
  input  logic          MemtoReg,
  input  logic [DW-1:0] ALUData,
  input  logic [DW-1:0] DMData,
  output logic [DW-1:0] readData1,
  output logic [DW-1:0] readData2
);

  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] regs [NREGS];

  wb_select #(
    .DW(DW),
    .AW(AW)
  ) u_wb_select (
    .RegDst  (RegDst),
    .MemtoReg(MemtoReg),
    .rt      (rt),
    .rd      (rd),
    .ALUData (ALUData),
    .DMData  (DMData),
    .waddr   (waddr),
    .wdata   (wdata)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && (waddr != REG_ZERO)) begin
      regs[waddr] <= wdata;
    end
  end

  // No write bypass: a read of the register being written shows the old value until the edge.
  assign readData1 = (rs == REG_ZERO) ? '0 : regs[rs];
  assign readData2 = (rt == REG_ZERO) ? '0 : regs[rt];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: vector table for write/read behaviour plus
// hand sequences for reset, no-bypass timing and mid-operation async reset.
module tb_reg_file;

  logic        CLK;
  logic        Reset;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic        RegWrite;
  logic        RegDst;
  logic        MemtoReg;
  logic [31:0] ALUData;
  logic [31:0] DMData;
  logic [31:0] readData1;
  logic [31:0] readData2;

  int errors = 0;
  int checks = 0;

  reg_file dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .RegWrite (RegWrite),
    .RegDst   (RegDst),
    .MemtoReg (MemtoReg),
    .ALUData  (ALUData),
    .DMData   (DMData),
    .readData1(readData1),
    .readData2(readData2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic        dst;
    logic        m2r;
    logic [4:0]  wrt;
    logic [4:0]  wrd;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [4:0]  rd_rs;
    logic [4:0]  rd_rt;
    logic [31:0] exp1;
    logic [31:0] exp2;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  initial begin
    // we dst m2r wrt wrd alu dm | read rs rt | expected rd1 rd2
    vecs[0] = '{1'b1, 1'b1, 1'b0, 5'd1,  5'd2,  32'h1,        32'h2,        5'd2,  5'd1,  32'h1,        32'h0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 5'd4,  5'd5,  32'h3,        32'h4,        5'd5,  5'd4,  32'h0,        32'h4};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'd4,  5'd5,  32'h0,        32'hDEAD,     5'd4,  5'd4,  32'h4,        32'h4};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 5'd3,  5'd0,  32'hFFFF_FFFF, 32'h0,       5'd0,  5'd3,  32'h0,        32'h0};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 5'd0,  5'd6,  32'h0,        32'h1234,     5'd0,  5'd6,  32'h0,        32'h0};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 5'd9,  5'd31, 32'hA5A5_A5A5, 32'h0,       5'd31, 5'd2,  32'hA5A5_A5A5, 32'h1};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 5'd31, 5'd8,  32'h0,        32'h1234_5678, 5'd31, 5'd31, 32'h1234_5678, 32'h1234_5678};
    vecs[7] = '{1'b0, 1'b1, 1'b0, 5'd4,  5'd2,  32'hFFFF,     32'hFFFF,     5'd2,  5'd4,  32'h1,        32'h4};
    vecs[8] = '{1'b1, 1'b1, 1'b1, 5'd2,  5'd4,  32'h0,        32'hCAFE_F00D, 5'd4,  5'd2,  32'hCAFE_F00D, 32'h1};

    Reset = 1'b0; rs = 5'd1; rt = 5'd31; rd = 5'd1;
    RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b0;
    ALUData = 32'h5555_5555; DMData = 32'h6666_6666;
    #2;
    check("reset_rd1", readData1, 32'h0);
    check("reset_rd2", readData2, 32'h0);
    // An edge during reset must not write register 1.
    @(posedge CLK); #1;
    check("reset_dominates_rd1", readData1, 32'h0);

    @(negedge CLK);
    Reset = 1'b1;
    RegWrite = 1'b0;
    @(posedge CLK); #1;
    check("post_reset_rd1", readData1, 32'h0);
    check("post_reset_rd2", readData2, 32'h0);

    for (int i = 0; i < 9; i++) begin
      RegWrite = vecs[i].we;  RegDst = vecs[i].dst; MemtoReg = vecs[i].m2r;
      rt = vecs[i].wrt;       rd = vecs[i].wrd;
      ALUData = vecs[i].alu;  DMData = vecs[i].dm;
      @(posedge CLK); #1;
      RegWrite = 1'b0;
      rs = vecs[i].rd_rs;     rt = vecs[i].rd_rt;
      #1;
      check($sformatf("vec%0d_rd1", i), readData1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), readData2, vecs[i].exp2);
    end

    // Read of the register being written: old value before the edge, new after.
    @(negedge CLK);
    RegWrite = 1'b1; RegDst = 1'b1; MemtoReg = 1'b0;
    rd = 5'd7; rs = 5'd7; rt = 5'd7; ALUData = 32'h77; DMData = 32'h88;
    #3;
    check("nobypass_pre_rd1", readData1, 32'h0);
    check("nobypass_pre_rd2", readData2, 32'h0);
    @(posedge CLK); #1;
    RegWrite = 1'b0;
    check("nobypass_post_rd1", readData1, 32'h77);
    check("nobypass_post_rd2", readData2, 32'h77);

    // Async reset between edges clears immediately.
    rs = 5'd2; rt = 5'd4;
    @(negedge CLK); #1;
    check("pre_async_rd1", readData1, 32'h1);
    check("pre_async_rd2", readData2, 32'hCAFE_F00D);
    Reset = 1'b0;
    #1;
    check("async_reset_rd1", readData1, 32'h0);
    check("async_reset_rd2", readData2, 32'h0);
    #1;
    Reset = 1'b1;
    rs = 5'd31; rt = 5'd7;
    #1;
    check("after_async_rd1", readData1, 32'h0);
    check("after_async_rd2", readData2, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
